// File: rtl/cache_pkg.sv
// Shared cache-subsystem definitions: default widths, the write-back entry
// record and a byte-lane merge helper for the default configuration.
package cache_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int BE_WIDTH   = DATA_WIDTH / 8;

   typedef struct packed {
      logic                  vld;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic [BE_WIDTH-1:0]   be;
   } wb_entry_t;

   // Replace the byte lanes of old_data selected by be with those of new_data.
   function automatic logic [DATA_WIDTH-1:0] byte_merge(
      input logic [DATA_WIDTH-1:0] old_data,
      input logic [DATA_WIDTH-1:0] new_data,
      input logic [BE_WIDTH-1:0]   be
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_data;
      for (int b = 0; b < BE_WIDTH; b++) begin
         if (be[b]) begin
            res[8*b +: 8] = new_data[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_data[8*b +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_cam_lookup.sv
// Associative search over the write-back entries: folds every matching entry
// from oldest to newest and reports the newest match for write coalescing.
module wb_cam_lookup #(
   parameter  int DEPTH      = 4,
   parameter  int ADDR_WIDTH = 32,
   parameter  int DATA_WIDTH = 32,
   localparam int BE_WIDTH   = DATA_WIDTH / 8,
   localparam int PTR_W      = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]                 ent_vld,
   input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr,
   input  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data,
   input  logic [DEPTH-1:0][BE_WIDTH-1:0]   ent_be,
   input  logic [PTR_W-1:0]                 head,
   input  logic [ADDR_WIDTH-1:0]            query_addr,
   output logic                             hit,
   output logic [DATA_WIDTH-1:0]            merged_data,
   output logic [BE_WIDTH-1:0]              merged_be,
   output logic [PTR_W-1:0]                 newest_idx,
   output logic                             newest_vld
);

   // Age-ordered fold: later (newer) matches overwrite earlier byte lanes.
   always_comb begin
      logic [PTR_W-1:0] idx_v;
      idx_v       = '0;
      hit         = 1'b0;
      merged_data = '0;
      merged_be   = '0;
      newest_idx  = '0;
      newest_vld  = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
         idx_v = head + PTR_W'(a);
         if (ent_vld[idx_v] && (ent_addr[idx_v] == query_addr)) begin
            hit        = 1'b1;
            newest_vld = 1'b1;
            newest_idx = idx_v;
            merged_be  = merged_be | ent_be[idx_v];
            for (int b = 0; b < BE_WIDTH; b++) begin
               if (ent_be[idx_v][b]) begin
                  merged_data[8*b +: 8] = ent_data[idx_v][8*b +: 8];
               end else begin
                  merged_data[8*b +: 8] = merged_data[8*b +: 8];
               end
            end
         end else begin
            merged_be = merged_be;
         end
      end
   end

endmodule

// File: rtl/wb_coalesce_buffer.sv
// Write-back buffer with write coalescing and byte-accurate lookup forwarding;
// entries drain in FIFO order and the head entry is frozen while offered.
module wb_coalesce_buffer #(
   parameter  int ADDR_WIDTH = cache_pkg::ADDR_WIDTH,
   parameter  int DATA_WIDTH = cache_pkg::DATA_WIDTH,
   parameter  int DEPTH      = 4,
   localparam int BE_WIDTH   = DATA_WIDTH / 8,
   localparam int PTR_W      = $clog2(DEPTH),
   localparam int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  wr_valid_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [BE_WIDTH-1:0]   wr_be_i,
   output logic                  wr_ready_o,
   input  logic [ADDR_WIDTH-1:0] lk_addr_i,
   output logic                  lk_hit_o,
   output logic [DATA_WIDTH-1:0] lk_data_o,
   output logic [BE_WIDTH-1:0]   lk_be_o,
   output logic                  dr_valid_o,
   input  logic                  dr_ready_i,
   output logic [ADDR_WIDTH-1:0] dr_addr_o,
   output logic [DATA_WIDTH-1:0] dr_data_o,
   output logic [BE_WIDTH-1:0]   dr_be_o,
   output logic [CNT_W-1:0]      count_o
);

   logic [DEPTH-1:0]                 vld_r;
   logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_r;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] data_r;
   logic [DEPTH-1:0][BE_WIDTH-1:0]   be_r;
   logic [PTR_W-1:0]                 head_r;
   logic [PTR_W-1:0]                 tail_r;
   logic [CNT_W-1:0]                 count_r;

   logic                  w_match_s;
   logic [PTR_W-1:0]      w_idx_s;
   logic                  w_hit_unused_s;
   logic [DATA_WIDTH-1:0] w_data_unused_s;
   logic [BE_WIDTH-1:0]   w_be_unused_s;
   logic [PTR_W-1:0]      lk_idx_unused_s;
   logic                  lk_nvld_unused_s;
   logic                  merge_ok_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  alloc_s;
   logic                  merge_s;
   logic [DATA_WIDTH-1:0] merge_data_s;

   wb_cam_lookup #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lk_cam (
      .ent_vld(vld_r), .ent_addr(addr_r), .ent_data(data_r), .ent_be(be_r),
      .head(head_r), .query_addr(lk_addr_i),
      .hit(lk_hit_o), .merged_data(lk_data_o), .merged_be(lk_be_o),
      .newest_idx(lk_idx_unused_s), .newest_vld(lk_nvld_unused_s)
   );

   wb_cam_lookup #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wr_cam (
      .ent_vld(vld_r), .ent_addr(addr_r), .ent_data(data_r), .ent_be(be_r),
      .head(head_r), .query_addr(wr_addr_i),
      .hit(w_hit_unused_s), .merged_data(w_data_unused_s), .merged_be(w_be_unused_s),
      .newest_idx(w_idx_s), .newest_vld(w_match_s)
   );

   // Push/pop decisions; the head is excluded as a merge target so it stays stable.
   always_comb begin
      merge_ok_s = w_match_s && (w_idx_s != head_r);
      wr_ready_o = merge_ok_s || (count_r < CNT_W'(DEPTH));
      push_s     = wr_valid_i && wr_ready_o;
      dr_valid_o = (count_r != '0);
      pop_s      = dr_valid_o && dr_ready_i;
      alloc_s    = push_s && !merge_ok_s && (wr_be_i != '0);
      merge_s    = push_s && merge_ok_s && (wr_be_i != '0);
      dr_addr_o  = addr_r[head_r];
      dr_data_o  = data_r[head_r];
      dr_be_o    = be_r[head_r];
      count_o    = count_r;
   end

   // New contents of the coalescing target.
   always_comb begin
      merge_data_s = data_r[w_idx_s];
      for (int b = 0; b < BE_WIDTH; b++) begin
         if (wr_be_i[b]) begin
            merge_data_s[8*b +: 8] = wr_data_i[8*b +: 8];
         end else begin
            merge_data_s[8*b +: 8] = data_r[w_idx_s][8*b +: 8];
         end
      end
   end

   // Entry storage, pointers and occupancy.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         vld_r   <= '0;
         addr_r  <= '0;
         data_r  <= '0;
         be_r    <= '0;
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         if (pop_s) begin
            vld_r[head_r] <= 1'b0;
            head_r        <= head_r + PTR_W'(1);
         end
         if (alloc_s) begin
            vld_r[tail_r]  <= 1'b1;
            addr_r[tail_r] <= wr_addr_i;
            data_r[tail_r] <= wr_data_i;
            be_r[tail_r]   <= wr_be_i;
            tail_r         <= tail_r + PTR_W'(1);
         end
         if (merge_s) begin
            data_r[w_idx_s] <= merge_data_s;
            be_r[w_idx_s]   <= be_r[w_idx_s] | wr_be_i;
         end
         case ({alloc_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_coalesce_buffer.sv
// Directed bench for wb_coalesce_buffer with hand-computed expectations.
module tb_wb_coalesce_buffer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        wr_valid;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        wr_ready;
   logic [31:0] lk_addr;
   logic        lk_hit;
   logic [31:0] lk_data;
   logic [3:0]  lk_be;
   logic        dr_valid;
   logic        dr_ready;
   logic [31:0] dr_addr;
   logic [31:0] dr_data;
   logic [3:0]  dr_be;
   logic [2:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   wb_coalesce_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
      .wr_ready_o(wr_ready),
      .lk_addr_i(lk_addr), .lk_hit_o(lk_hit), .lk_data_o(lk_data), .lk_be_o(lk_be),
      .dr_valid_o(dr_valid), .dr_ready_i(dr_ready),
      .dr_addr_o(dr_addr), .dr_data_o(dr_data), .dr_be_o(dr_be),
      .count_o(count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      wr_be    = be;
      step();
      wr_valid = 1'b0;
      wr_be    = 4'h0;
   endtask

   initial begin
      rstn = 1'b0; wr_valid = 1'b0; wr_addr = 32'd0; wr_data = 32'd0; wr_be = 4'h0;
      lk_addr = 32'd0; dr_ready = 1'b0;
      #1;
      chk("rst_dr_valid", dr_valid, 1'b0);
      chk("rst_count", count, 3'd0);
      chk("rst_wr_ready", wr_ready, 1'b1);
      chk("rst_lk_hit", lk_hit, 1'b0);
      chk("rst_lk_data", lk_data, 32'd0);
      chk("rst_dr_addr", dr_addr, 32'd0);
      #12 rstn = 1'b1;
      step();

      // Fill to capacity, then drain in order
      push(32'd12, 32'd1, 4'hF);
      push(32'd13, 32'd2, 4'hF);
      push(32'd14, 32'd3, 4'hF);
      push(32'd15, 32'd4, 4'hF);
      chk("full_count", count, 3'd4);
      wr_valid = 1'b1; wr_addr = 32'd16; wr_be = 4'hF; #1;
      chk("full_new_ready", wr_ready, 1'b0);
      wr_addr = 32'd13; #1;
      chk("full_merge_ready", wr_ready, 1'b1);
      wr_valid = 1'b0; wr_be = 4'h0;
      dr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_valid", dr_valid, 1'b1);
         chk("drain_addr", dr_addr, 32'd12 + 32'(i));
         chk("drain_data", dr_data, 32'd1 + 32'(i));
         step();
      end
      dr_ready = 1'b0;
      chk("empty_count", count, 3'd0);
      chk("empty_valid", dr_valid, 1'b0);

      // Coalesce into a non-head entry
      push(32'd20, 32'h11223344, 4'hF);
      push(32'd21, 32'h00000000, 4'hF);
      push(32'd21, 32'hAABB0000, 4'hC);
      chk("coal_count", count, 3'd2);
      lk_addr = 32'd21; #1;
      chk("coal_lk_hit", lk_hit, 1'b1);
      chk("coal_lk_data", lk_data, 32'hAABB0000);
      chk("coal_lk_be", lk_be, 4'hF);
      dr_ready = 1'b1;
      chk("coal_dr0_data", dr_data, 32'h11223344);
      step();
      chk("coal_dr1_addr", dr_addr, 32'd21);
      chk("coal_dr1_data", dr_data, 32'hAABB0000);
      chk("coal_dr1_be", dr_be, 4'hF);
      step();
      dr_ready = 1'b0;

      // A match on the head only allocates a duplicate
      push(32'd20, 32'h11223344, 4'hF);
      push(32'd20, 32'h000000FF, 4'h1);
      chk("dup_count", count, 3'd2);
      lk_addr = 32'd20; #1;
      chk("dup_lk_data", lk_data, 32'h112233FF);
      chk("dup_lk_be", lk_be, 4'hF);
      chk("dup_dr_data", dr_data, 32'h11223344);
      dr_ready = 1'b1; step();
      chk("dup_dr1_data", dr_data, 32'h000000FF);
      chk("dup_dr1_be", dr_be, 4'h1);
      step();
      dr_ready = 1'b0;

      // Partial byte enables, lookup miss, zero-byte-enable push
      push(32'd30, 32'h0000CD00, 4'h2);
      lk_addr = 32'd30; #1;
      chk("part_lk_hit", lk_hit, 1'b1);
      chk("part_lk_data", lk_data, 32'h0000CD00);
      chk("part_lk_be", lk_be, 4'h2);
      lk_addr = 32'd31; #1;
      chk("miss_lk_hit", lk_hit, 1'b0);
      chk("miss_lk_data", lk_data, 32'd0);
      chk("miss_lk_be", lk_be, 4'h0);
      wr_valid = 1'b1; wr_addr = 32'd40; wr_data = 32'hDEADBEEF; wr_be = 4'h0; #1;
      chk("be0_ready", wr_ready, 1'b1);
      step();
      wr_valid = 1'b0;
      chk("be0_count", count, 3'd1);
      dr_ready = 1'b1; step(); dr_ready = 1'b0;

      // Full buffer: pop does not free a same-cycle allocate
      for (int i = 0; i < 4; i++) push(32'd50 + 32'(i), 32'h50 + 32'(i), 4'hF);
      dr_ready = 1'b1;
      wr_valid = 1'b1; wr_addr = 32'd60; wr_data = 32'h60; wr_be = 4'hF; #1;
      chk("fullpop_ready", wr_ready, 1'b0);
      step();
      wr_valid = 1'b0; dr_ready = 1'b0;
      chk("fullpop_count", count, 3'd3);
      chk("fullpop_head", dr_addr, 32'd51);
      push(32'd54, 32'h54, 4'hF);
      // Full buffer: merge plus pop
      dr_ready = 1'b1;
      wr_valid = 1'b1; wr_addr = 32'd53; wr_data = 32'h0000AB00; wr_be = 4'h2; #1;
      chk("mergepop_ready", wr_ready, 1'b1);
      step();
      chk("mergepop_count", count, 3'd3);
      lk_addr = 32'd53; #1;
      chk("mergepop_lk_data", lk_data, 32'h0000AB53);
      // Merge into head+1 while the head pops
      wr_addr = 32'd53; wr_data = 32'h00CD0000; wr_be = 4'h4;
      step();
      wr_valid = 1'b0; wr_be = 4'h0;
      chk("nextmerge_count", count, 3'd2);
      chk("nextmerge_addr", dr_addr, 32'd53);
      chk("nextmerge_data", dr_data, 32'h00CDAB53);

      // Asynchronous reset while entries are offered
      #2 rstn = 1'b0;
      #1;
      chk("arst_dr_valid", dr_valid, 1'b0);
      chk("arst_count", count, 3'd0);
      dr_ready = 1'b0;
      #2 rstn = 1'b1;
      step();
      push(32'd70, 32'h77, 4'hF);
      chk("post_count", count, 3'd1);
      chk("post_dr_addr", dr_addr, 32'd70);
      chk("post_idx0_addr", dut.addr_r[0], 32'd70);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
